branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side next-PC predictor that sits directly upstream of the IF/ID pipeline register, beside PC and InstMemory.
- Each cycle it looks up the current fetch PC and returns a predicted next PC and a taken flag.
- The EX stage sends resolved branch/jump outcomes back through an update port.
- Organisation: gshare pattern history table (PHT) of 2-bit counters, plus a direct-mapped branch target buffer (BTB).

Parameters:
- IDX_BITS, 5, log2 of entries in both the BTB and the PHT (32 entries each).
- GHR_BITS, 5, global history length; legal range 1..IDX_BITS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (reset==0 resets the block).
- pc  input  32  current fetch PC, word-aligned.
- pred_taken  output  1  prediction for pc is taken.
- pred_next_pc  output  32  predicted next fetch PC.
- update_valid  input  1  a resolved control-flow instruction is presented this cycle.
- update_is_jump  input  1  1 = JAL/JALR, 0 = conditional branch.
- update_pc  input  32  PC of the resolved instruction.
- update_taken  input  1  resolved direction; ignored when update_is_jump=1 (treated as 1).
- update_target  input  32  resolved target address.

Behaviour:
- Fields: idx = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2]; PHT index = idx XOR zero-extended GHR. Update-side fields use the same formulas on update_pc.
- BTB entry contents: valid, tag, target[31:0], is_jump.
- BTB hit: entry at idx is valid and its tag matches.
- Prediction is combinational from pc and the current state, in the same cycle:
  - jump hit -> taken;
  - branch hit -> taken iff PHT counter bit[1]=1;
  - miss -> not taken.
- pred_next_pc = BTB target if pred_taken, else pc+4 (32-bit wrap).
- Counter encoding: 00 strongly not-taken (SN), 01 weakly not-taken (WN), 10 weakly taken (WT), 11 strongly taken (ST).
- Counters saturate: taken at 11 stays 11; not-taken at 00 stays 00.
- Updates happen on the rising edge when update_valid=1:
  - Branch: the PHT counter at the update index, computed with the GHR value before this edge, increments if taken, decrements if not. Then GHR <= {GHR[GHR_BITS-2:0], update_taken}.
  - Jump: PHT and GHR are untouched.
  - BTB on branch taken or any jump: write the entry at the update idx with valid=1, the tag, update_target and is_jump. This overwrites any alias.
  - BTB on branch not taken: the entry is left unchanged.
- GHR is updated non-speculatively, at resolve time only.
- Same-cycle lookup and update of the same entry: the prediction uses pre-edge state; there is no bypass.
- When update_valid=0, no state changes.
- Reset (asynchronous, takes effect immediately, mid-operation included):
  - all BTB valid bits = 0;
  - all PHT counters = 01 (WN);
  - GHR = 0.
  - Outputs therefore become pred_taken=0 and pred_next_pc=pc+4 without waiting for a clock edge.
- Latency: prediction 0 cycles; an update is visible to lookups on the cycle after its edge.
- Flushing on misprediction is the pipeline's job, not this block's.

Decomposition:
- Shared package holds:
  - the counter encodings SN/WN/WT/ST;
  - the reset counter value WN;
  - the instruction-alignment constant (2 offset bits);
  - the btb_entry struct: valid, tag, target, is_jump.
- One sub-module, btb_table: direct-mapped tag/target/valid array with a combinational read port and a synchronous write port, with the same asynchronous active-low reset.
- The PHT and GHR stay in the top module.

Test Plan:
- Reset, then pc=0x40 -> pred_taken=0, pred_next_pc=0x44.
- Six consecutive taken branch updates at update_pc=0x40, target 0x100:
  - PHT indices touched: 0x10, 0x11, 0x13, 0x17, 0x1F, 0x0F; GHR ends at 11111.
  - After update 5, pc=0x40 -> not taken, pred_next_pc=0x44.
  - After update 6 -> taken, pred_next_pc=0x100.
- Jump update at pc=0x80, target 0x200 -> next cycle pc=0x80 gives taken/0x200, GHR unchanged; then pc=0x100 (same idx, different tag) -> not taken/0x104.
- Saturation: drive the counter at PHT index 0x0F to 11, then three more taken updates -> counter stays 11; one not-taken update -> 10, still predicts taken.
- Update and lookup of pc=0x40 in the same cycle -> the output in that cycle reflects the old state; the new state shows the following cycle.
- Pull reset low between clock edges after training -> pred_taken=0 and pred_next_pc=pc+4 immediately; after release, all previously trained PCs miss.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the gshare + BTB next-PC predictor.
package branch_predictor_pkg;

  localparam int ALIGN_BITS = 2;
  localparam int TAG_MAX_W  = 32 - ALIGN_BITS;

  typedef enum logic [1:0] {
    CTR_SN = 2'b00,
    CTR_WN = 2'b01,
    CTR_WT = 2'b10,
    CTR_ST = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WN;

  // Tag is stored zero-extended to the widest possible tag so the struct is
  // independent of the table depth.
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic                 is_jump;
  } btb_entry_t;

  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    if (taken && c != CTR_ST)       n = ctr_e'(2'(c) + 2'd1);
    else if (!taken && c != CTR_SN) n = ctr_e'(2'(c) - 2'd1);
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_table.sv
// Direct-mapped branch target buffer: combinational read, synchronous write.
module btb_table
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  output btb_entry_t          o_rd_entry,
  input  logic                i_wr_en,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  btb_entry_t          i_wr_entry
);

  localparam int ENTRIES = 1 << IDX_BITS;

  btb_entry_t r_mem [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_entry;
    end
  end

  assign o_rd_entry = r_mem[i_rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side next-PC predictor: gshare PHT of 2-bit counters plus a BTB.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = 5,
  parameter int GHR_BITS = 5   // 1..IDX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  input  logic        update_valid,
  input  logic        update_is_jump,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int LO      = ALIGN_BITS;
  localparam int HI      = IDX_BITS + ALIGN_BITS;

  ctr_e                r_pht [ENTRIES];
  logic [GHR_BITS-1:0] r_ghr;
  logic [GHR_BITS-1:0] w_ghr_next;
  logic [IDX_BITS-1:0] w_ghr_ext;

  logic [IDX_BITS-1:0]  w_idx, w_upd_idx, w_pidx, w_upd_pidx;
  logic [TAG_MAX_W-1:0] w_tag, w_upd_tag;
  btb_entry_t           w_rd_entry, w_wr_entry;
  logic                 w_hit, w_btb_wr, w_pht_wr;
  logic [31:0]          w_pc_plus4;
  logic                 w_unused_lsbs;

  assign w_idx      = pc[HI-1:LO];
  assign w_tag      = TAG_MAX_W'(pc[31:HI]);
  assign w_upd_idx  = update_pc[HI-1:LO];
  assign w_upd_tag  = TAG_MAX_W'(update_pc[31:HI]);
  assign w_ghr_ext  = IDX_BITS'(r_ghr);
  assign w_pidx     = w_idx ^ w_ghr_ext;
  assign w_upd_pidx = w_upd_idx ^ w_ghr_ext;

  assign w_unused_lsbs = ^{pc[LO-1:0], update_pc[LO-1:0]};

  generate
    if (GHR_BITS == 1) begin : g_ghr1
      assign w_ghr_next = update_taken;
    end else begin : g_ghrn
      assign w_ghr_next = {r_ghr[GHR_BITS-2:0], update_taken};
    end
  endgenerate

  // Jumps train the BTB only; history and counters track conditional branches.
  assign w_pht_wr = update_valid && !update_is_jump;
  assign w_btb_wr = update_valid && (update_is_jump || update_taken);

  always_comb begin
    w_wr_entry         = '0;
    w_wr_entry.valid   = 1'b1;
    w_wr_entry.tag     = w_upd_tag;
    w_wr_entry.target  = update_target;
    w_wr_entry.is_jump = update_is_jump;
  end

  btb_table #(.IDX_BITS(IDX_BITS)) u_btb (
    .clk        (clk),
    .rst_n      (reset),
    .i_rd_idx   (w_idx),
    .o_rd_entry (w_rd_entry),
    .i_wr_en    (w_btb_wr),
    .i_wr_idx   (w_upd_idx),
    .i_wr_entry (w_wr_entry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) r_pht[i] <= CTR_RESET;
      r_ghr <= '0;
    end else if (w_pht_wr) begin
      r_pht[w_upd_pidx] <= ctr_next(r_pht[w_upd_pidx], update_taken);
      r_ghr             <= w_ghr_next;
    end
  end

  // Lookup sees pre-edge state only; a same-cycle update is not bypassed.
  assign w_hit      = w_rd_entry.valid && (w_rd_entry.tag == w_tag);
  assign w_pc_plus4 = pc + 32'd4;

  always_comb begin
    pred_taken = 1'b0;
    if (w_hit) pred_taken = w_rd_entry.is_jump || r_pht[w_pidx][1];
    pred_next_pc = pred_taken ? w_rd_entry.target : w_pc_plus4;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded bench: directed scenarios then random traffic against a
// behavioural predictor model.
module tb_branch_predictor;

  localparam int IDX  = 5;
  localparam int GHRB = 5;
  localparam int NENT = 1 << IDX;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        update_valid, update_is_jump, update_taken;
  logic [31:0] update_pc, update_target;

  branch_predictor #(.IDX_BITS(IDX), .GHR_BITS(GHRB)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .pred_next_pc   (pred_next_pc),
    .update_valid   (update_valid),
    .update_is_jump (update_is_jump),
    .update_pc      (update_pc),
    .update_taken   (update_taken),
    .update_target  (update_target)
  );

  always #5 clk = ~clk;

  // Reference model state: plain integers and arrays.
  int          m_ctr   [NENT];
  bit          m_valid [NENT];
  longint      m_tag   [NENT];
  bit          m_jump  [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_ghr;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] next;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic int idx_of(input logic [31:0] a);
    return int'((longint'(a) / 4) % NENT);
  endfunction

  function automatic longint tag_of(input logic [31:0] a);
    return longint'(a) / (4 * NENT);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_ctr[i] = 1; m_valid[i] = 0; m_tag[i] = 0; m_jump[i] = 0; m_tgt[i] = '0;
    end
    m_ghr = 0;
  endfunction

  function automatic exp_t model_predict(input logic [31:0] a);
    exp_t e;
    int   i;
    bit   t;
    i = idx_of(a);
    t = 0;
    if (m_valid[i] && m_tag[i] == tag_of(a))
      t = m_jump[i] || (m_ctr[i ^ m_ghr] >= 2);
    e.pc    = a;
    e.taken = t;
    e.next  = t ? m_tgt[i] : a + 32'd4;
    return e;
  endfunction

  function automatic void model_update(input bit uj, input logic [31:0] upc,
                                       input bit ut, input logic [31:0] tgt);
    int i, p;
    i = idx_of(upc);
    if (!uj) begin
      p = i ^ m_ghr;
      if (ut) m_ctr[p] = (m_ctr[p] == 3) ? 3 : m_ctr[p] + 1;
      else    m_ctr[p] = (m_ctr[p] == 0) ? 0 : m_ctr[p] - 1;
      m_ghr = (m_ghr * 2 + int'(ut)) % (1 << GHRB);
    end
    if (uj || ut) begin
      m_valid[i] = 1; m_tag[i] = tag_of(upc); m_tgt[i] = tgt; m_jump[i] = uj;
    end
  endfunction

  // One cycle: drive, record expected lookup from pre-edge model, advance model.
  task automatic step(input logic [31:0] p, input bit uv, input bit uj,
                      input logic [31:0] upc, input bit ut, input logic [31:0] tgt);
    pc = p; update_valid = uv; update_is_jump = uj;
    update_pc = upc; update_taken = ut; update_target = tgt;
    exp_q.push_back(model_predict(p));
    if (uv && rst_n) model_update(uj, upc, ut, tgt);
    @(posedge clk); #1;
  endtask

  task automatic look(input logic [31:0] p);
    step(p, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic br(input logic [31:0] p, input logic [31:0] upc, input bit ut,
                    input logic [31:0] tgt);
    step(p, 1, 0, upc, ut, tgt);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if (pred_taken !== e.taken || pred_next_pc !== e.next) begin
        n_fail++;
        $display("FAIL predict pc=%h: got taken=%b next=%h, want taken=%b next=%h",
                 e.pc, pred_taken, pred_next_pc, e.taken, e.next);
      end
    end
  end

  initial begin
    logic [31:0] rp, up, tg;
    rst_n = 1'b0; pc = 32'h40; update_valid = 0; update_is_jump = 0;
    update_pc = 0; update_taken = 0; update_target = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    look(32'h40);                                   // reset state: 0x44
    for (int k = 0; k < 6; k++) br(32'h40, 32'h40, 1, 32'h100);
    look(32'h40);                                   // trained: taken -> 0x100

    step(32'h40, 1, 1, 32'h80, 1, 32'h200);         // jump, GHR untouched
    look(32'h80);
    look(32'h100);                                  // alias idx, other tag
    look(32'h40);

    // Saturation on PHT[0x0F], then one not-taken leaves it weakly taken.
    br(32'h40, 32'h44, 1, 32'h300);
    for (int k = 0; k < 4; k++) br(32'h40, 32'h40, 1, 32'h100);
    br(32'h40, 32'h40, 0, 32'h100);
    look(32'h44);
    look(32'h40);

    // Same-cycle update and lookup of 0x40: old state this cycle.
    br(32'h40, 32'h40, 0, 32'h100);
    look(32'h40);
    look(32'h80);

    // Asynchronous reset between edges.
    pc = 32'h80; update_valid = 0;
    #1 rst_n = 1'b0;
    model_reset();
    exp_q.push_back(model_predict(32'h80));
    @(posedge clk); #1;
    look(32'h40);
    rst_n = 1'b1;
    look(32'h40);
    look(32'h80);
    look(32'h44);

    // Random traffic over a small address pool so hits and aliases occur.
    for (int k = 0; k < 1500; k++) begin
      rp = 32'($urandom_range(0, 3)) * 32'd128 + 32'($urandom_range(0, 31)) * 32'd4;
      up = 32'($urandom_range(0, 3)) * 32'd128 + 32'($urandom_range(0, 31)) * 32'd4;
      if ($urandom_range(0, 49) == 0) rp = 32'hFFFF_FFFC;
      tg = $urandom() & 32'hFFFF_FFFC;
      step(rp, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, up,
           $urandom_range(0, 1) == 1, tg);
    end

    @(negedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
